// File: rtl/ula_multiciclo_pkg.sv
// Shared opcode and state definitions for the multi-cycle ALU.
package ula_multiciclo_pkg;

  typedef enum logic [2:0] {
    OP_ADDU = 3'd0,
    OP_ADDS = 3'd1,
    OP_MULS = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_SLT  = 3'd6,
    OP_MULU = 3'd7
  } op_e;

  typedef enum logic {
    OCIOSO  = 1'b0,
    CALCULA = 1'b1
  } estado_e;

  function automatic logic eh_mult(input op_e op);
    return (op == OP_MULS) || (op == OP_MULU);
  endfunction

endpackage

// File: rtl/ula_multiciclo_multiplicador.sv
// Unsigned shift-add multiplier core: one partial product per clock, LARGURA steps.
module multiplicador_seq #(
  parameter int LARGURA = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     a,
  input  logic [LARGURA-1:0]     b,
  output logic                   fim,
  output logic [2*LARGURA-1:0]   produto
);

  localparam int LARG_CONT = $clog2(LARGURA + 1);

  logic [LARGURA-1:0]   mcand_q;
  logic [2*LARGURA-1:0] prod_q, prod_d;
  logic [LARG_CONT-1:0] cont_q;
  logic [LARGURA:0]     soma;

  // Upper half accumulates, lower half holds the remaining multiplier bits.
  always_comb begin
    soma   = {1'b0, prod_q[2*LARGURA-1:LARGURA]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {soma, prod_q[LARGURA-1:1]};
  end

  // fim flags the edge that performs the final iteration; produto is its result.
  assign fim     = (cont_q == LARG_CONT'(1));
  assign produto = prod_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cont_q  <= '0;
    end else if (inicio) begin
      mcand_q <= a;
      prod_q  <= {{LARGURA{1'b0}}, b};
      cont_q  <= LARG_CONT'(LARGURA);
    end else if (cont_q != '0) begin
      prod_q  <= prod_d;
      cont_q  <= cont_q - 1'b1;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered ALU: single-cycle ops answer in one cycle, multiplies run LARGURA cycles.
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               valido,
  input  logic [2:0]         Operacao,
  input  logic [LARGURA-1:0] in1,
  input  logic [LARGURA-1:0] in2,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] saida,
  output logic [LARGURA-1:0] saida_alta,
  output logic               saida_comp,
  output logic               zero,
  output logic               overflow
);

  localparam int MSB = LARGURA - 1;
  localparam int LP  = 2 * LARGURA;

  estado_e            estado_q;
  op_e                op;
  logic               ocupado_q, pronto_q, comp_q, zero_q, ovf_q;
  logic [LARGURA-1:0] saida_q, alta_q;
  logic               sinal_q, eh_mulu_q, comp_pend_q;

  logic [LARGURA:0]   soma;
  logic [LARGURA-1:0] dif, res_d, mag_a, mag_b;
  logic               ovf_d, inicio, mul_fim, mul_ovf;
  logic [LP-1:0]      mul_prod, prod_s;

  assign op = op_e'(Operacao);

  always_comb begin
    soma  = {1'b0, in1} + {1'b0, in2};
    dif   = in1 - in2;
    res_d = '0;
    ovf_d = 1'b0;
    case (op)
      OP_ADDU: begin res_d = soma[MSB:0]; ovf_d = soma[LARGURA]; end
      OP_ADDS: begin
        res_d = soma[MSB:0];
        ovf_d = (in1[MSB] == in2[MSB]) && (soma[MSB] != in1[MSB]);
      end
      OP_SUB: begin
        res_d = dif;
        ovf_d = (in1[MSB] != in2[MSB]) && (dif[MSB] != in1[MSB]);
      end
      OP_AND:  res_d = in1 & in2;
      OP_OR:   res_d = in1 | in2;
      OP_SLT:  res_d = {{(LARGURA-1){1'b0}}, $signed(in1) < $signed(in2)};
      default: res_d = '0;
    endcase
  end

  // MULS feeds magnitudes to the unsigned core; -2^(LARGURA-1) still fits unsigned.
  always_comb begin
    mag_a = in1;
    mag_b = in2;
    if (op == OP_MULS) begin
      if (in1[MSB]) mag_a = ~in1 + LARGURA'(1);
      if (in2[MSB]) mag_b = ~in2 + LARGURA'(1);
    end
  end

  assign inicio = (estado_q == OCIOSO) && valido && eh_mult(op);

  multiplicador_seq #(.LARGURA(LARGURA)) u_mult (
    .clock   (clock),
    .reset_n (reset_n),
    .inicio  (inicio),
    .a       (mag_a),
    .b       (mag_b),
    .fim     (mul_fim),
    .produto (mul_prod)
  );

  always_comb begin
    prod_s  = sinal_q ? (~mul_prod + LP'(1)) : mul_prod;
    mul_ovf = eh_mulu_q ? (prod_s[LP-1:LARGURA] != '0)
                        : (prod_s[LP-1:LARGURA] != {LARGURA{prod_s[MSB]}});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      saida_q     <= '0;
      alta_q      <= '0;
      comp_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sinal_q     <= 1'b0;
      eh_mulu_q   <= 1'b0;
      comp_pend_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (valido) begin
            if (eh_mult(op)) begin
              estado_q    <= CALCULA;
              ocupado_q   <= 1'b1;
              sinal_q     <= (op == OP_MULS) && (in1[MSB] ^ in2[MSB]);
              eh_mulu_q   <= (op == OP_MULU);
              comp_pend_q <= (in1 == in2);
            end else begin
              saida_q  <= res_d;
              alta_q   <= '0;
              comp_q   <= (in1 == in2);
              zero_q   <= (res_d == '0);
              ovf_q    <= ovf_d;
              pronto_q <= 1'b1;
            end
          end
        end
        CALCULA: begin
          if (mul_fim) begin
            saida_q   <= prod_s[MSB:0];
            alta_q    <= prod_s[LP-1:LARGURA];
            comp_q    <= comp_pend_q;
            zero_q    <= (prod_s[MSB:0] == '0);
            ovf_q     <= mul_ovf;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign ocupado    = ocupado_q;
  assign pronto     = pronto_q;
  assign saida      = saida_q;
  assign saida_alta = alta_q;
  assign saida_comp = comp_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: directed cases plus random ops against an arithmetic model.
module tb_ula_multiciclo;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         valido = 1'b0;
  logic [2:0]   Operacao = '0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         ocupado, pronto, saida_comp, zero, overflow;
  logic [W-1:0] saida, saida_alta;

  int n_checks = 0;
  int n_erros  = 0;

  always #5 clock = ~clock;

  ula_multiciclo #(.LARGURA(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .valido     (valido),
    .Operacao   (Operacao),
    .in1        (in1),
    .in2        (in2),
    .ocupado    (ocupado),
    .pronto     (pronto),
    .saida      (saida),
    .saida_alta (saida_alta),
    .saida_comp (saida_comp),
    .zero       (zero),
    .overflow   (overflow)
  );

  task automatic verifica(input string tag, input int obs, input int esp);
    n_checks++;
    if (obs != esp) begin
      n_erros++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  function automatic int sx(input int v);
    return (v > SMAX) ? v - (1 << W) : v;
  endfunction

  // Expected outputs from plain integer arithmetic on the operation's meaning.
  task automatic modelo(input int op, input int a, input int b,
                        output int lo, output int hi, output int comp,
                        output int zr, output int ovf, output int lat);
    int r;
    int full;
    ovf = 0;
    case (op)
      0: begin r = a + b;           ovf = int'(r > MASK); end
      1: begin r = sx(a) + sx(b);   ovf = int'(r > SMAX || r < SMIN); end
      2: begin r = sx(a) * sx(b);   ovf = int'(r > SMAX || r < SMIN); end
      3: begin r = sx(a) - sx(b);   ovf = int'(r > SMAX || r < SMIN); end
      4: r = a & b;
      5: r = a | b;
      6: r = int'(sx(a) < sx(b));
      default: begin r = a * b;     ovf = int'(r > MASK); end
    endcase
    full = r & ((1 << (2 * W)) - 1);
    lo   = full & MASK;
    hi   = (op == 2 || op == 7) ? ((full >> W) & MASK) : 0;
    comp = int'(a == b);
    zr   = int'(lo == 0);
    lat  = (op == 2 || op == 7) ? W : 0;
  endtask

  task automatic executa(input int op, input int a, input int b, input string nome);
    int lo, hi, comp, zr, ovf, lat;
    int n, nocup;
    modelo(op, a, b, lo, hi, comp, zr, ovf, lat);
    valido   = 1'b1;
    Operacao = 3'(op);
    in1      = W'(a);
    in2      = W'(b);
    @(posedge clock); #1;
    valido = 1'b0;
    n = 0;
    nocup = 0;
    while (!pronto && n < 3 * W) begin
      if (ocupado) nocup++;
      valido   = 1'($urandom_range(0, 1));
      Operacao = 3'($urandom);
      in1      = W'($urandom);
      in2      = W'($urandom);
      @(posedge clock); #1;
      n++;
    end
    valido = 1'b0;
    verifica({nome, ".latencia"}, n, lat);
    verifica({nome, ".ocupado_ciclos"}, nocup, lat);
    verifica({nome, ".pronto"}, int'(pronto), 1);
    verifica({nome, ".ocupado_fim"}, int'(ocupado), 0);
    verifica({nome, ".saida"}, int'(saida), lo);
    verifica({nome, ".saida_alta"}, int'(saida_alta), hi);
    verifica({nome, ".saida_comp"}, int'(saida_comp), comp);
    verifica({nome, ".zero"}, int'(zero), zr);
    verifica({nome, ".overflow"}, int'(overflow), ovf);
  endtask

  task automatic verifica_zerado(input string nome);
    verifica({nome, ".saida"}, int'(saida), 0);
    verifica({nome, ".saida_alta"}, int'(saida_alta), 0);
    verifica({nome, ".saida_comp"}, int'(saida_comp), 0);
    verifica({nome, ".zero"}, int'(zero), 0);
    verifica({nome, ".overflow"}, int'(overflow), 0);
    verifica({nome, ".pronto"}, int'(pronto), 0);
    verifica({nome, ".ocupado"}, int'(ocupado), 0);
  endtask

  function automatic int operando();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1 << (W - 1);
      2: return MASK;
      default: return int'($urandom_range(0, MASK));
    endcase
  endfunction

  initial begin
    int npr;
    #12;
    verifica_zerado("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    executa(0, 200, 100, "addu_carry");
    executa(1, 100, 50, "adds_ovf");
    executa(1, 253, 5, "adds_b2b");
    executa(2, 249, 6, "muls_neg");
    executa(2, 128, 128, "muls_min");
    executa(7, 255, 255, "mulu_max");
    executa(3, 'h5A, 'h5A, "sub_igual");
    executa(6, 255, 1, "slt_neg");
    executa(2, 5, 5, "muls_5x5");

    // Reset in the middle of a multiply aborts it and clears everything.
    @(negedge clock);
    valido = 1'b1; Operacao = 3'd2; in1 = W'(5); in2 = W'(5);
    @(posedge clock); #1;
    valido = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 verifica_zerado("reset_meio");
    @(negedge clock);
    reset_n = 1'b1;
    npr = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clock); #1;
      if (pronto) npr++;
    end
    verifica("reset_meio.sem_pronto", npr, 0);
    executa(0, 7, 9, "pos_reset");
    executa(2, 3, 250, "pos_reset_mul");

    for (int i = 0; i < 150; i++) begin
      int a, b, op;
      op = int'($urandom_range(0, 7));
      a  = operando();
      b  = ($urandom_range(0, 7) == 0) ? a : operando();
      executa(op, a, b, "aleatorio");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
        verifica("pronto_pulso", int'(pronto), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_erros, n_checks);
    $fatal(1);
  end

endmodule
